// File: rtl/can_ifc_apb_seq.sv
// APB slave that splits one 32-bit APB access into up to four byte-wide CAN
// register strobes, with configurable read latency, strobe masking and error reporting.
module can_ifc_apb_seq #(
  parameter int PACKED    = 1,
  parameter int REG_COUNT = 256,
  parameter int REG_AW    = 8,
  parameter int RD_LAT    = 1,
  parameter int USE_PSTRB = 1,
  parameter int PRIV_ONLY = 0
) (
  input  logic              aclk,
  input  logic              arstn,
  input  logic [31:0]       s_apb_paddr,
  input  logic              s_apb_psel,
  input  logic              s_apb_penable,
  input  logic              s_apb_pwrite,
  input  logic [31:0]       s_apb_pwdata,
  input  logic [3:0]        s_apb_pstrb,
  input  logic [2:0]        s_apb_pprot,
  output logic [31:0]       s_apb_prdata,
  output logic              s_apb_pready,
  output logic              s_apb_pslverr,
  output logic              reg_rst_o,
  output logic              reg_re_o,
  output logic              reg_we_o,
  output logic [REG_AW-1:0] reg_addr_o,
  output logic [7:0]        reg_data_in_o,
  input  logic [7:0]        reg_data_out_i,
  output logic [1:0]        fsm_state
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_STROBE = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  // APB handshake: a transfer starts on psel & ~penable; this block alone decides
  // completion by raising pready for exactly one cycle in DONE.
  logic [1:0]        state;
  logic [REG_AW+1:0] base;
  logic              write;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic [3:0]        mask;
  logic              err;
  logic [1:0]        wcnt;
  logic [1:0]        rst_sync;

  logic [REG_AW-1:0] word;
  logic [REG_AW+1:0] new_base;
  logic [3:0]        strb_eff;
  logic [3:0]        new_mask;
  logic              bad;
  logic [1:0]        lane;
  logic [3:0]        rest;
  logic [REG_AW+1:0] lane_idx;
  logic              strobing;
  logic              unused_bits;

  assign word        = s_apb_paddr[REG_AW+1:2];
  assign unused_bits = ^{s_apb_paddr[31:REG_AW+2], s_apb_paddr[1:0], s_apb_pprot[2:1]};

  always_comb begin
    new_base = (PACKED != 0) ? {word, 2'b00} : {2'b00, word};
    strb_eff = (USE_PSTRB != 0) ? s_apb_pstrb : 4'hF;
    if (s_apb_pwrite) new_mask = (PACKED != 0) ? strb_eff : {3'b000, strb_eff[0]};
    else              new_mask = (PACKED != 0) ? 4'hF : 4'h1;
    for (int i = 0; i < 4; i++)
      if (32'(new_base) + 32'(i) >= 32'(REG_COUNT)) new_mask[i] = 1'b0;
    bad = (32'(new_base) >= 32'(REG_COUNT)) || ((PRIV_ONLY != 0) && !s_apb_pprot[0]);
  end

  // Lowest pending lane is serviced first; it stays selected until captured.
  always_comb begin
    if (mask[0])      lane = 2'd0;
    else if (mask[1]) lane = 2'd1;
    else if (mask[2]) lane = 2'd2;
    else              lane = 2'd3;
    rest     = mask & ~(4'b0001 << lane);
    lane_idx = base + (REG_AW + 2)'(lane);
  end

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      state <= S_IDLE;
      base  <= '0;
      write <= 1'b0;
      wdata <= '0;
      rdata <= '0;
      mask  <= '0;
      err   <= 1'b0;
      wcnt  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (s_apb_psel && !s_apb_penable) begin
            base  <= new_base;
            write <= s_apb_pwrite;
            wdata <= s_apb_pwdata;
            rdata <= '0;
            wcnt  <= '0;
            err   <= bad;
            mask  <= bad ? 4'h0 : new_mask;
            state <= (bad || new_mask == 4'h0) ? S_DONE : S_STROBE;
          end
        end
        S_STROBE: begin
          if (!s_apb_psel) begin
            state <= S_IDLE;
          end else if (write || RD_LAT == 0) begin
            if (!write) rdata[{lane, 3'b000} +: 8] <= reg_data_out_i;
            mask  <= rest;
            state <= (rest == 4'h0) ? S_DONE : S_STROBE;
          end else begin
            wcnt  <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!s_apb_psel) begin
            state <= S_IDLE;
          end else if (wcnt == 2'(RD_LAT - 1)) begin
            rdata[{lane, 3'b000} +: 8] <= reg_data_out_i;
            mask  <= rest;
            state <= (rest == 4'h0) ? S_DONE : S_STROBE;
          end else begin
            wcnt <= wcnt + 2'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Register-file reset: asserted immediately, released two clocks after arstn rises.
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign reg_rst_o     = ~rst_sync[1];
  assign strobing      = (state == S_STROBE) && s_apb_psel;
  assign reg_we_o      = strobing && write;
  assign reg_re_o      = strobing && !write;
  assign reg_addr_o    = (state == S_STROBE || state == S_WAIT) ? lane_idx[REG_AW-1:0] : '0;
  assign reg_data_in_o = reg_we_o ? wdata[{lane, 3'b000} +: 8] : 8'h00;
  assign s_apb_pready  = (state == S_DONE);
  assign s_apb_pslverr = s_apb_pready && err;
  assign s_apb_prdata  = s_apb_pready ? rdata : 32'h0;
  assign fsm_state     = state;

endmodule

// File: tb/tb_can_ifc_apb_seq.sv
// Bench for can_ifc_apb_seq: three differently parameterised instances share one APB
// bus; expected strobes and completions are queued by the driver and checked by a monitor.
module tb_can_ifc_apb_seq;

  logic        aclk = 1'b0;
  logic        arstn = 1'b0;
  logic [31:0] paddr = '0;
  logic [2:0]  psel = '0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic [2:0]  pprot = '0;

  logic [31:0] prdata[3];
  logic        pready[3];
  logic        pslverr[3];
  logic        rrst[3];
  logic        re[3];
  logic        we[3];
  logic [7:0]  raddr[3];
  logic [7:0]  din[3];
  logic [1:0]  fst[3];
  logic [7:0]  d0, d1, d2;

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;

  logic [18:0] exp_q[$];   // {dut, we, addr, data}
  logic [42:0] done_q[$];  // {dut, err, prdata, latency}

  // clock / reset block
  always #5 aclk = ~aclk;
  always @(posedge aclk) cyc <= cyc + 1;

  can_ifc_apb_seq #(.PACKED(1), .REG_COUNT(256), .REG_AW(8), .RD_LAT(1), .USE_PSTRB(1), .PRIV_ONLY(0)) u_dut0 (
    .aclk(aclk), .arstn(arstn), .s_apb_paddr(paddr), .s_apb_psel(psel[0]), .s_apb_penable(penable),
    .s_apb_pwrite(pwrite), .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb), .s_apb_pprot(pprot),
    .s_apb_prdata(prdata[0]), .s_apb_pready(pready[0]), .s_apb_pslverr(pslverr[0]),
    .reg_rst_o(rrst[0]), .reg_re_o(re[0]), .reg_we_o(we[0]), .reg_addr_o(raddr[0]),
    .reg_data_in_o(din[0]), .reg_data_out_i(d0), .fsm_state(fst[0]));

  can_ifc_apb_seq #(.PACKED(1), .REG_COUNT(6), .REG_AW(8), .RD_LAT(0), .USE_PSTRB(0), .PRIV_ONLY(1)) u_dut1 (
    .aclk(aclk), .arstn(arstn), .s_apb_paddr(paddr), .s_apb_psel(psel[1]), .s_apb_penable(penable),
    .s_apb_pwrite(pwrite), .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb), .s_apb_pprot(pprot),
    .s_apb_prdata(prdata[1]), .s_apb_pready(pready[1]), .s_apb_pslverr(pslverr[1]),
    .reg_rst_o(rrst[1]), .reg_re_o(re[1]), .reg_we_o(we[1]), .reg_addr_o(raddr[1]),
    .reg_data_in_o(din[1]), .reg_data_out_i(d1), .fsm_state(fst[1]));

  can_ifc_apb_seq #(.PACKED(0), .REG_COUNT(256), .REG_AW(8), .RD_LAT(2), .USE_PSTRB(1), .PRIV_ONLY(0)) u_dut2 (
    .aclk(aclk), .arstn(arstn), .s_apb_paddr(paddr), .s_apb_psel(psel[2]), .s_apb_penable(penable),
    .s_apb_pwrite(pwrite), .s_apb_pwdata(pwdata), .s_apb_pstrb(pstrb), .s_apb_pprot(pprot),
    .s_apb_prdata(prdata[2]), .s_apb_pready(pready[2]), .s_apb_pslverr(pslverr[2]),
    .reg_rst_o(rrst[2]), .reg_re_o(re[2]), .reg_we_o(we[2]), .reg_addr_o(raddr[2]),
    .reg_data_in_o(din[2]), .reg_data_out_i(d2), .fsm_state(fst[2]));

  // Register-file models return the register index, valid only RD_LAT cycles after re.
  logic       p0_v = 1'b0, p2_v1 = 1'b0, p2_v2 = 1'b0;
  logic [7:0] p0_a = '0, p2_a1 = '0, p2_a2 = '0;
  always @(posedge aclk) begin
    p0_v  <= re[0];
    p0_a  <= raddr[0];
    p2_v1 <= re[2];
    p2_a1 <= raddr[2];
    p2_v2 <= p2_v1;
    p2_a2 <= p2_a1;
  end
  assign d0 = p0_v ? p0_a : 8'hEE;
  assign d1 = re[1] ? raddr[1] : 8'hEE;
  assign d2 = p2_v2 ? p2_a2 : 8'hEE;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge aclk) begin
    if (arstn) begin
      for (int d = 0; d < 3; d++) begin
        if (re[d] && we[d]) check("re_we_exclusive", 64'(1), 64'(0));
        if (re[d] || we[d]) begin
          logic [18:0] act;
          act = {2'(d), we[d], raddr[d], we[d] ? din[d] : 8'h00};
          if (exp_q.size() == 0) check("unexpected_strobe", 64'(act), 64'h7FFFF);
          else check("strobe", 64'(act), 64'(exp_q.pop_front()));
        end
        if (pready[d]) begin
          logic [42:0] act_c;
          act_c = {2'(d), pslverr[d], prdata[d], 8'(cyc - start_cyc + 1)};
          if (done_q.size() == 0) check("unexpected_pready", 64'(act_c), 64'h7FF_FFFF_FFFF);
          else check("completion", 64'(act_c), 64'(done_q.pop_front()));
        end
      end
    end
  end

  // driver tasks
  task automatic push_we(input int d, input logic [7:0] idx, input logic [7:0] data);
    exp_q.push_back({2'(d), 1'b1, idx, data});
  endtask

  task automatic push_re(input int d, input logic [7:0] idx);
    exp_q.push_back({2'(d), 1'b0, idx, 8'h00});
  endtask

  task automatic push_done(input int d, input logic e, input logic [31:0] rd, input int lat);
    done_q.push_back({2'(d), e, rd, 8'(lat)});
  endtask

  task automatic apb(input int d, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                     input logic [3:0] st, input logic [2:0] pr);
    int n;
    @(posedge aclk); #1;
    psel = '0; psel[d] = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = wd; pstrb = st; pprot = pr;
    start_cyc = cyc;
    @(posedge aclk); #1;
    penable = 1'b1;
    n = 0;
    while (!pready[d] && n < 60) begin
      @(negedge aclk);
      n++;
    end
    if (!pready[d]) check("pready_timeout", 64'(0), 64'(1));
  endtask

  task automatic go_idle();
    @(posedge aclk); #1;
    psel = '0; penable = 1'b0;
  endtask

  initial begin
    #3;
    check("rst_pready", 64'(pready[0]), 64'(0));
    check("rst_strobes", 64'({re[0], we[0], re[1], we[1], re[2], we[2]}), 64'(0));
    check("rst_prdata", 64'(prdata[0]), 64'(0));
    check("rst_state", 64'(fst[0]), 64'(0));
    check("rst_reg_rst", 64'(rrst[0]), 64'(1));
    repeat (3) @(posedge aclk);
    #1 arstn = 1'b1;
    repeat (3) @(posedge aclk);
    #1 check("reg_rst_released", 64'(rrst[0]), 64'(0));

    // packed full-word write, then a back-to-back two-lane write
    push_we(0, 8'd4, 8'h11); push_we(0, 8'd5, 8'h22); push_we(0, 8'd6, 8'h33); push_we(0, 8'd7, 8'h44);
    push_done(0, 1'b0, 32'h0, 6);
    apb(0, 1'b1, 32'h04, 32'h44332211, 4'hF, 3'b000);
    push_we(0, 8'd8, 8'hAA); push_we(0, 8'd10, 8'hCC);
    push_done(0, 1'b0, 32'h0, 4);
    apb(0, 1'b1, 32'h08, 32'hDDCCBBAA, 4'b0101, 3'b000);
    push_done(0, 1'b0, 32'h0, 2);
    apb(0, 1'b1, 32'h08, 32'h12345678, 4'h0, 3'b000);
    // packed read with one wait state per byte
    push_re(0, 8'd4); push_re(0, 8'd5); push_re(0, 8'd6); push_re(0, 8'd7);
    push_done(0, 1'b0, 32'h07060504, 10);
    apb(0, 1'b0, 32'h04, 32'h0, 4'h0, 3'b000);
    // base index 256 is out of range
    push_done(0, 1'b1, 32'h0, 2);
    apb(0, 1'b0, 32'h100, 32'h0, 4'h0, 3'b000);
    go_idle();

    // REG_COUNT=6, PRIV_ONLY, pstrb ignored, zero read latency
    push_re(1, 8'd4); push_re(1, 8'd5);
    push_done(1, 1'b0, 32'h00000504, 4);
    apb(1, 1'b0, 32'h04, 32'h0, 4'h0, 3'b001);
    push_done(1, 1'b1, 32'h0, 2);
    apb(1, 1'b0, 32'h08, 32'h0, 4'h0, 3'b001);
    push_done(1, 1'b1, 32'h0, 2);
    apb(1, 1'b1, 32'h00, 32'hFFFFFFFF, 4'hF, 3'b000);
    push_we(1, 8'd0, 8'h12); push_we(1, 8'd1, 8'h34); push_we(1, 8'd2, 8'h56); push_we(1, 8'd3, 8'h78);
    push_done(1, 1'b0, 32'h0, 6);
    apb(1, 1'b1, 32'h00, 32'h78563412, 4'b0001, 3'b001);
    go_idle();

    // unpacked mapping, two-cycle read latency
    push_we(2, 8'd3, 8'hAB);
    push_done(2, 1'b0, 32'h0, 3);
    apb(2, 1'b1, 32'h0C, 32'h000000AB, 4'hF, 3'b000);
    push_done(2, 1'b0, 32'h0, 2);
    apb(2, 1'b1, 32'h0C, 32'h000000CD, 4'b1110, 3'b000);
    push_re(2, 8'd5);
    push_done(2, 1'b0, 32'h00000005, 5);
    apb(2, 1'b0, 32'h14, 32'h0, 4'h0, 3'b000);
    go_idle();

    // reset dropped while lane 2 of a write is being strobed
    push_we(0, 8'd4, 8'h11); push_we(0, 8'd5, 8'h22);
    @(posedge aclk); #1;
    psel = 3'b001; penable = 1'b0; pwrite = 1'b1; paddr = 32'h04;
    pwdata = 32'h44332211; pstrb = 4'hF; pprot = 3'b000;
    @(posedge aclk); #1 penable = 1'b1;
    @(posedge aclk);
    @(posedge aclk); #1 arstn = 1'b0;
    #1;
    check("abort_we", 64'(we[0]), 64'(0));
    check("abort_addr", 64'(raddr[0]), 64'(0));
    check("abort_pready", 64'(pready[0]), 64'(0));
    check("abort_state", 64'(fst[0]), 64'(0));
    check("abort_reg_rst", 64'(rrst[0]), 64'(1));
    psel = '0; penable = 1'b0;
    repeat (2) @(posedge aclk);
    #1 arstn = 1'b1;
    @(posedge aclk); #1 check("reg_rst_hold_1", 64'(rrst[0]), 64'(1));
    @(posedge aclk); #1 check("reg_rst_hold_2", 64'(rrst[0]), 64'(0));
    push_we(0, 8'd4, 8'hEF); push_we(0, 8'd5, 8'hBE);
    push_done(0, 1'b0, 32'h0, 4);
    apb(0, 1'b1, 32'h04, 32'h0000BEEF, 4'b0011, 3'b000);
    go_idle();

    repeat (10) @(posedge aclk);
    #1;
    check("strobe_queue_empty", 64'(exp_q.size()), 64'(0));
    check("done_queue_empty", 64'(done_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
